// File: rtl/hartslag_conditioner_pkg.sv
// Shared types and default timing constants for the heartbeat front-end
// and the downstream heart-rate stage.
package hartslag_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOST    = 2'd3
  } hs_state_e;

  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_DEBOUNCE_CYC = 16;
  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_MIN_IBI_MS   = 250;
  localparam int DEF_MAX_IBI_MS   = 2000;
  localparam int DEF_IBI_W        = 12;

endpackage

// File: rtl/hs_debounce.sv
// Synchroniser, level debouncer and rising-edge detector for the raw sensor line.
// rise is a one-cycle strobe registered together with the debounced level going high.
module hs_debounce
  import hartslag_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic                   db_q;
  logic                   rise_q;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // The count only advances while the synchronised level disagrees with db;
  // any agreement (a glitch back) restarts it from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      rise_q <= 1'b0;
      if (sync_lvl == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        cnt_q  <= '0;
        db_q   <= sync_lvl;
        rise_q <= sync_lvl;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/hartslag_conditioner.sv
// Heartbeat conditioner: debounced beat detection, IBI measurement in ms,
// artefact rejection below the minimum IBI and sensor-loss detection.
module hartslag_conditioner
  import hartslag_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MIN_IBI_MS   = DEF_MIN_IBI_MS,
  parameter int MAX_IBI_MS   = DEF_MAX_IBI_MS,
  parameter int IBI_W        = DEF_IBI_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sensorRaw,
  output logic             beatPulse,
  output logic [IBI_W-1:0] ibiMs,
  output logic             ibiValid,
  output logic             sensorLost,
  output logic [7:0]       artefactCnt
);

  localparam int PW = $clog2(TICK_DIV + 1);

  hs_state_e        state_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [IBI_W-1:0] ibi_q, ibi_d;
  logic [IBI_W-1:0] ibi_ms_q;
  logic [7:0]       art_q;
  logic             pulse_q, valid_q, lost_q;
  logic             db_w, rise_w, cand, tick, at_max;

  hs_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (sensorRaw),
    .db   (db_w),
    .rise (rise_w)
  );

  assign cand = rise_w & db_w;
  assign tick = (pre_q == PW'(TICK_DIV - 1));

  // ibi_d already includes a tick landing this cycle, so a beat exactly
  // N ms after the previous one measures N.
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    ibi_d = ibi_q;
    if (tick && (ibi_q != IBI_W'(MAX_IBI_MS))) begin
      ibi_d = ibi_q + 1'b1;
    end
  end

  assign at_max = (ibi_d == IBI_W'(MAX_IBI_MS));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      pre_q    <= '0;
      ibi_q    <= '0;
      ibi_ms_q <= '0;
      art_q    <= '0;
      pulse_q  <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      valid_q <= 1'b0;
      pre_q   <= pre_d;
      ibi_q   <= ibi_d;
      if (!enable) begin
        state_q <= ST_IDLE;
        lost_q  <= 1'b0;
        pre_q   <= '0;
        ibi_q   <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ACQUIRE;
            pre_q   <= '0;
            ibi_q   <= '0;
          end
          ST_ACQUIRE: begin
            if (cand) begin
              pulse_q <= 1'b1;
              pre_q   <= '0;
              ibi_q   <= '0;
              state_q <= ST_TRACK;
            end
          end
          ST_TRACK: begin
            if (cand) begin
              if (ibi_d < IBI_W'(MIN_IBI_MS)) begin
                if (art_q != 8'hFF) art_q <= art_q + 1'b1;
              end else begin
                pulse_q  <= 1'b1;
                valid_q  <= 1'b1;
                ibi_ms_q <= ibi_d;
                pre_q    <= '0;
                ibi_q    <= '0;
              end
            end else if (at_max) begin
              state_q <= ST_LOST;
              lost_q  <= 1'b1;
            end
          end
          ST_LOST: begin
            if (cand) begin
              pulse_q <= 1'b1;
              pre_q   <= '0;
              ibi_q   <= '0;
              lost_q  <= 1'b0;
              state_q <= ST_TRACK;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign beatPulse   = pulse_q;
  assign ibiValid    = valid_q;
  assign ibiMs       = ibi_ms_q;
  assign sensorLost  = lost_q;
  assign artefactCnt = art_q;

endmodule

// File: tb/tb_hartslag_conditioner.sv
// Bench for hartslag_conditioner with scaled timing (4 clk per ms, 3-cycle debounce).
// Expected beats are queued when a sensor edge is driven and matched when beatPulse fires.
`timescale 1ns/1ps
module tb_hartslag_conditioner;

  localparam int IBI_W = 12;
  localparam int LAT   = 2 + 3 + 1;

  typedef struct {
    int period;
    int high;
    bit pulse;
    bit valid;
    int ibi;
    int art;
    bit lost;
  } vec_t;

  typedef struct {
    int stamp;
    bit valid;
    int ibi;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             sensorRaw = 1'b0;
  logic             beatPulse;
  logic [IBI_W-1:0] ibiMs;
  logic             ibiValid;
  logic             sensorLost;
  logic [7:0]       artefactCnt;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t tbl[14];

  hartslag_conditioner #(
    .SYNC_STAGES (2),
    .DEBOUNCE_CYC(3),
    .TICK_DIV    (4),
    .MIN_IBI_MS  (5),
    .MAX_IBI_MS  (20),
    .IBI_W       (IBI_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sensorRaw  (sensorRaw),
    .beatPulse  (beatPulse),
    .ibiMs      (ibiMs),
    .ibiValid   (ibiValid),
    .sensorLost (sensorLost),
    .artefactCnt(artefactCnt)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_missed();
    while (sb.size() > 0 && sb[0].stamp <= cyc) begin
      n_vec++;
      n_miss++;
      $display("FAIL missed_pulse: got none by cycle %0d, want pulse at cycle %0d", cyc, sb[0].stamp);
      void'(sb.pop_front());
    end
  endtask

  task automatic drive_beat(input int period, input int high, input bit pulse,
                            input bit valid, input int ibi);
    exp_t e;
    @(negedge clk);
    sensorRaw = 1'b1;
    if (pulse) begin
      e.stamp = cyc + LAT;
      e.valid = valid;
      e.ibi   = ibi;
      sb.push_back(e);
    end
    repeat (high) @(negedge clk);
    sensorRaw = 1'b0;
    repeat (period - high - 1) @(negedge clk);
    check_missed();
  endtask

  // Monitor: pops one expectation per beatPulse and checks timing and IBI.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (reset) begin
        if (beatPulse) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_pulse: got beatPulse at cycle %0d, want none", cyc);
          end else begin
            e = sb.pop_front();
            check("pulse_cycle", cyc, e.stamp);
            check("ibiValid", int'(ibiValid), int'(e.valid));
            check("ibiMs", int'(ibiMs), e.ibi);
            $display("beat: cycle %0d ibiValid=%0b ibiMs=%0d", cyc, ibiValid, ibiMs);
          end
        end else if (ibiValid) begin
          n_vec++;
          n_miss++;
          $display("FAIL stray_ibiValid: got ibiValid=1 with beatPulse=0 at cycle %0d, want 0", cyc);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          period high pulse valid ibi art lost
    tbl[0]  = '{40, 8, 1'b1, 1'b0,  0, 0, 1'b0};  // first beat from ACQUIRE
    tbl[1]  = '{40, 8, 1'b1, 1'b1, 10, 0, 1'b0};
    tbl[2]  = '{20, 8, 1'b1, 1'b1, 10, 0, 1'b0};
    tbl[3]  = '{20, 2, 1'b0, 1'b0,  0, 0, 1'b0};  // 2-clk glitch
    tbl[4]  = '{12, 6, 1'b1, 1'b1, 10, 0, 1'b0};
    tbl[5]  = '{28, 6, 1'b0, 1'b0,  0, 1, 1'b0};  // 3 ms artefact
    tbl[6]  = '{40, 8, 1'b1, 1'b1, 10, 1, 1'b0};
    tbl[7]  = '{19, 8, 1'b1, 1'b1, 10, 1, 1'b0};
    tbl[8]  = '{21, 8, 1'b0, 1'b0,  0, 2, 1'b0};  // 4 ms: just below MIN
    tbl[9]  = '{20, 8, 1'b1, 1'b1, 10, 2, 1'b0};
    tbl[10] = '{80, 8, 1'b1, 1'b1,  5, 2, 1'b0};  // exactly MIN
    tbl[11] = '{100, 8, 1'b1, 1'b1, 20, 2, 1'b1}; // beat on MAX, then loss
    tbl[12] = '{40, 8, 1'b1, 1'b0, 20, 2, 1'b0};  // recovery from LOST
    tbl[13] = '{40, 8, 1'b1, 1'b1, 10, 2, 1'b0};

    // Reset held with the sensor toggling
    reset  = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      sensorRaw = ~sensorRaw;
      check("reset_outputs", int'({beatPulse, ibiValid, sensorLost, artefactCnt, ibiMs}), 0);
    end
    sensorRaw = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      drive_beat(tbl[i].period, tbl[i].high, tbl[i].pulse, tbl[i].valid, tbl[i].ibi);
      check("artefactCnt", int'(artefactCnt), tbl[i].art);
      check("sensorLost", int'(sensorLost), int'(tbl[i].lost));
      $display("vector %0d: period=%0d high=%0d artefactCnt=%0d sensorLost=%0b",
               i, tbl[i].period, tbl[i].high, artefactCnt, sensorLost);
    end

    // 300 artefacts: each group is one valid beat followed by two beats at 2 and 4 ms
    for (int g = 0; g < 150; g++) begin
      drive_beat(8, 4, 1'b1, 1'b1, (g == 0) ? 10 : 6);
      drive_beat(8, 4, 1'b0, 1'b0, 0);
      drive_beat(8, 4, 1'b0, 1'b0, 0);
      if (g == 0)   check("artefact_count_g0", int'(artefactCnt), 4);
      if (g == 100) check("artefact_count_g100", int'(artefactCnt), 204);
    end
    check("artefact_saturated", int'(artefactCnt), 255);
    $display("artefact burst done: artefactCnt=%0d", artefactCnt);

    // Disable mid-TRACK: beats ignored, ibiMs and artefactCnt hold
    @(negedge clk);
    enable = 1'b0;
    drive_beat(20, 8, 1'b0, 1'b0, 0);
    drive_beat(20, 8, 1'b0, 1'b0, 0);
    check("disabled_ibiMs_hold", int'(ibiMs), 6);
    check("disabled_art_hold", int'(artefactCnt), 255);
    check("disabled_lost", int'(sensorLost), 0);

    // Sensor already high when enable rises: no beat
    @(negedge clk);
    sensorRaw = 1'b1;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    sensorRaw = 1'b0;
    repeat (10) @(negedge clk);
    drive_beat(40, 8, 1'b1, 1'b0, 6);
    drive_beat(40, 8, 1'b1, 1'b1, 10);
    $display("re-enable done: ibiMs=%0d", ibiMs);

    // Reset asserted mid-debounce
    @(negedge clk);
    sensorRaw = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_reset_outputs", int'({beatPulse, ibiValid, sensorLost, artefactCnt, ibiMs}), 0);
    sensorRaw = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("post_reset_outputs", int'({beatPulse, ibiValid, sensorLost, artefactCnt, ibiMs}), 0);
    drive_beat(40, 8, 1'b1, 1'b0, 0);
    $display("post-reset beat done: ibiMs=%0d artefactCnt=%0d", ibiMs, artefactCnt);

    repeat (10) @(negedge clk);
    check_missed();
    check("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
